// File: rtl/hough_vote_if.sv
// Vote stream handshake between the Hough calculate stage (master) and the
// vote accumulator (slave).
interface hough_vote_if;
    logic              vote_valid;
    logic              vote_ready;
    logic signed [12:0] vote_r;
    logic        [7:0]  vote_angle;

    modport master (output vote_valid, output vote_r, output vote_angle, input vote_ready);
    modport slave  (input vote_valid, input vote_r, input vote_angle, output vote_ready);
endinterface

// File: rtl/hough_vote_accumulator.sv
// Hough vote accumulator: bins (r, angle) votes and increments per-bin tallies in an
// external read-first dual-port BRAM; includes a clear sweep. Optional stats: HOUGH_ACC_STATS_EN.
module hough_vote_accumulator #(
    parameter int R_MAX      = 800,
    parameter int ANGLE_BINS = 45,
    parameter int COUNT_W    = 16,
    parameter int ADDR_W     = 15
) (
    input  logic               clk,
    input  logic               reset,
    hough_vote_if.slave        vote,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [COUNT_W-1:0] mem_rdata,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [COUNT_W-1:0] mem_wdata,
    output logic [15:0]        votes_accepted,
    output logic [15:0]        votes_dropped
);

    localparam int                 NUM_BINS  = (R_MAX / 2 + 1) * ANGLE_BINS;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_BINS - 1);
    localparam logic signed [13:0] R_MAX_S   = 14'(R_MAX);
    localparam logic [7:0]         ANGLE_MAX = 8'(4 * (ANGLE_BINS - 1));

    typedef enum logic {
        ACCUM = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_addr;
    logic                accept;
    logic                clear_go;
    logic                clear_last;

    logic signed [13:0]  r_ext;
    logic signed [13:0]  r_off;
    logic signed [13:0]  r_bin;
    logic                bin_ok;
    logic [ADDR_W-1:0]   bin_addr;

    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic                fw_valid;
    logic [ADDR_W-1:0]   fw_addr;
    logic [COUNT_W-1:0]  fw_data;
    logic [COUNT_W-1:0]  base;
    logic [COUNT_W-1:0]  inc_data;

    assign vote.vote_ready = (state == ACCUM) && !clear_start;
    assign accept          = vote.vote_valid && vote.vote_ready;
    assign clear_go        = (state == ACCUM) && clear_start;
    assign clear_last      = (state == CLEAR) && (sweep_addr == LAST_ADDR);

    // NOTE: every variable driven in always_comb gets a default on every path, otherwise a latch is inferred.
    always_comb begin
        r_ext    = {vote.vote_r[12], vote.vote_r};
        r_off    = r_ext + R_MAX_S;
        r_bin    = r_off >>> 2;
        bin_ok   = (vote.vote_angle[1:0] == 2'b00) && (vote.vote_angle <= ANGLE_MAX) &&
                   (r_ext >= -R_MAX_S) && (r_ext <= R_MAX_S);
        bin_addr = ADDR_W'(r_bin) * ADDR_W'(ANGLE_BINS) + ADDR_W'(vote.vote_angle[7:2]);
    end

    assign mem_raddr = bin_addr;

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCUM;
            sweep_addr <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        sweep_addr <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state      <= ACCUM;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            fw_valid <= 1'b0;
        end else begin
            s1_valid <= accept && bin_ok;
            fw_valid <= s1_valid && !clear_go;
        end
    end

    // NOTE: payload registers are not reset; their valid bits gate every use, as with the BRAM itself.
    always_ff @(posedge clk) begin
        s1_addr <= bin_addr;
        fw_addr <= s1_addr;
        fw_data <= inc_data;
    end

    // The BRAM is read-first, so a write issued last cycle is invisible to this cycle's read data.
    always_comb begin
        base     = (fw_valid && (fw_addr == s1_addr)) ? fw_data : mem_rdata;
        inc_data = (&base) ? base : base + 1'b1;
        mem_we    = 1'b0;
        mem_waddr = s1_addr;
        mem_wdata = inc_data;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = sweep_addr;
                mem_wdata = '0;
            end else if (s1_valid) begin
                mem_we = 1'b1;
            end
        end
    end

`ifdef HOUGH_ACC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || clear_last) begin
            votes_accepted <= '0;
            votes_dropped  <= '0;
        end else if (accept) begin
            if (bin_ok) begin
                if (!(&votes_accepted)) votes_accepted <= votes_accepted + 1'b1;
            end else begin
                if (!(&votes_dropped)) votes_dropped <= votes_dropped + 1'b1;
            end
        end
    end
`else
    assign votes_accepted = 16'd0;
    assign votes_dropped  = 16'd0;
`endif

endmodule

// File: tb/tb_hough_vote_accumulator.sv
// Self-checking bench for hough_vote_accumulator: read-first BRAM model, per-bin tally
// reference model, vote table, hand-written corner sequences and random votes.
module tb_hough_vote_accumulator;

    localparam int R_MAX      = 800;
    localparam int ANGLE_BINS = 45;
    localparam int COUNT_W    = 16;
    localparam int ADDR_W     = 15;
    localparam int NUM_BINS   = (R_MAX / 2 + 1) * ANGLE_BINS;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear_start;
    logic               clear_busy;
    logic               clear_done;
    logic [ADDR_W-1:0]  mem_raddr;
    logic [COUNT_W-1:0] mem_rdata;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [COUNT_W-1:0] mem_wdata;
    logic [15:0]        votes_accepted;
    logic [15:0]        votes_dropped;

    hough_vote_if vif ();

    hough_vote_accumulator #(
        .R_MAX(R_MAX), .ANGLE_BINS(ANGLE_BINS), .COUNT_W(COUNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .vote(vif),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .votes_accepted(votes_accepted), .votes_dropped(votes_dropped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read-first dual-port BRAM
    logic [COUNT_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Reference model: tally per bin, clear sweep progress, stats
    int  ref_count [NUM_BINS];
    bit  pend_v;
    int  pend_addr;
    bit  clr_active;
    int  clr_idx;
    bit  done_exp;
    int  m_acc, m_drop;

    function automatic bit model_bin(input int r, input int ang, output int addr);
        addr = ((r + R_MAX) / 4) * ANGLE_BINS + ang / 4;
        return (ang % 4 == 0) && (ang <= 4 * (ANGLE_BINS - 1)) && (r >= -R_MAX) && (r <= R_MAX);
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    always @(negedge clk) begin : monitor
        int  a;
        bit  ok;
        int  e;
        if (reset) begin
            check("mem_we_in_reset", mem_we, 0);
            pend_v = 0; clr_active = 0; clr_idx = 0; done_exp = 0; m_acc = 0; m_drop = 0;
        end else begin
            check("clear_busy", clear_busy, clr_active);
            check("clear_done", clear_done, done_exp);
            check("vote_ready", vif.vote_ready, !clr_active && !clear_start);
            check("mem_we", mem_we, pend_v || clr_active);
            if (clr_active) begin
                check("sweep_waddr", mem_waddr, clr_idx);
                check("sweep_wdata", mem_wdata, 0);
                ref_count[clr_idx] = 0;
            end else if (pend_v) begin
                e = sat_inc(ref_count[pend_addr], (1 << COUNT_W) - 1);
                check("vote_waddr", mem_waddr, pend_addr);
                check("vote_wdata", mem_wdata, e);
                ref_count[pend_addr] = e;
            end
`ifdef HOUGH_ACC_STATS_EN
            check("votes_accepted", votes_accepted, m_acc);
            check("votes_dropped", votes_dropped, m_drop);
`else
            check("votes_accepted_off", votes_accepted, 0);
            check("votes_dropped_off", votes_dropped, 0);
`endif
            done_exp = clr_active && (clr_idx == NUM_BINS - 1);
            pend_v   = 0;
            if (clr_active) begin
                if (clr_idx == NUM_BINS - 1) begin
                    clr_active = 0; m_acc = 0; m_drop = 0;
                end else begin
                    clr_idx++;
                end
            end else if (clear_start) begin
                clr_active = 1; clr_idx = 0;
            end else if (vif.vote_valid) begin
                ok = model_bin(int'(vif.vote_r), int'(vif.vote_angle), a);
                if (ok) begin
                    check("mem_raddr", mem_raddr, a);
                    pend_v = 1; pend_addr = a;
                    m_acc  = sat_inc(m_acc, 16'hFFFF);
                end else begin
                    m_drop = sat_inc(m_drop, 16'hFFFF);
                end
            end
        end
    end

    typedef struct {
        int r;
        int angle;
        bit ok;
        int addr;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vote(input bit v, input int r, input int ang);
        vif.vote_valid = v;
        vif.vote_r     = 13'(r);
        vif.vote_angle = 8'(ang);
    endtask

    task automatic run_full_clear();
        int busy_n = 0;
        int done_n = 0;
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < NUM_BINS + 100; c++) begin
            @(negedge clk);
            if (clear_busy) busy_n++;
            if (clear_done) begin done_n++; break; end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (clear_done) done_n++;
        end
        check("clear_busy_cycles", busy_n, NUM_BINS);
        check("clear_done_pulses", done_n, 1);
    endtask

    initial begin
        vecs[0]  = '{0,    88,  1, 9022};
        vecs[1]  = '{-800, 176, 1, 44};
        vecs[2]  = '{800,  0,   1, 18000};
        vecs[3]  = '{800,  176, 1, 18044};
        vecs[4]  = '{801,  0,   0, 0};
        vecs[5]  = '{0,    2,   0, 0};
        vecs[6]  = '{0,    180, 0, 0};
        vecs[7]  = '{-801, 0,   0, 0};
        vecs[8]  = '{-797, 4,   1, 1};
        vecs[9]  = '{-1,   0,   1, 8955};
        vecs[10] = '{3,    8,   1, 9002};

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'hA5A5;
        for (int i = 0; i < NUM_BINS; i++) ref_count[i] = 16'hA5A5;

        reset = 1'b1; clear_start = 1'b0;
        drive_vote(0, 0, 0);
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_vote_ready", vif.vote_ready, 1);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_votes_accepted", votes_accepted, 0);
        check("rst_votes_dropped", votes_dropped, 0);

        run_full_clear();

        // Three out-of-range votes back to back
        tick(); drive_vote(1, 801, 0);
        tick(); drive_vote(1, 0, 2);
        tick(); drive_vote(1, 0, 180);
        tick(); drive_vote(0, 0, 0);
        @(negedge clk);
        check("drop_no_we", mem_we, 0);
        tick();
        @(negedge clk);
`ifdef HOUGH_ACC_STATS_EN
        check("drop_votes_dropped", votes_dropped, 3);
`else
        check("drop_votes_dropped", votes_dropped, 0);
`endif
        check("drop_votes_accepted", votes_accepted, 0);

        // Single vote after clear: latency one cycle, count 1
        tick(); drive_vote(1, 0, 88);
        @(negedge clk);
        check("v9022_raddr", mem_raddr, 9022);
        tick(); drive_vote(0, 0, 0);
        @(negedge clk);
        check("v9022_we", mem_we, 1);
        check("v9022_waddr", mem_waddr, 9022);
        check("v9022_wdata", mem_wdata, 1);

        // Back-to-back same bin exercises forwarding
        tick(); drive_vote(1, -800, 176);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) drive_vote(0, 0, 0);
            @(negedge clk);
            check("b2b_we", mem_we, 1);
            check("b2b_waddr", mem_waddr, 44);
            check("b2b_wdata", mem_wdata, i + 1);
        end

        // Table of vectors, one isolated vote each
        for (int i = 0; i < 11; i++) begin
            tick(); drive_vote(1, vecs[i].r, vecs[i].angle);
            @(negedge clk);
            if (vecs[i].ok) check("tbl_raddr", mem_raddr, vecs[i].addr);
            tick(); drive_vote(0, 0, 0);
            @(negedge clk);
            check("tbl_we", mem_we, vecs[i].ok);
            if (vecs[i].ok) check("tbl_waddr", mem_waddr, vecs[i].addr);
        end

        // Saturation
        tick();
        mem[9022] = 16'hFFFF; ref_count[9022] = 16'hFFFF;
        drive_vote(1, 0, 88);
        tick(); drive_vote(0, 0, 0);
        @(negedge clk);
        check("sat_wdata", mem_wdata, 16'hFFFF);

        // clear_start while s1 holds a vote, then reset mid-sweep
        tick(); drive_vote(1, 0, 4);
        tick(); clear_start = 1'b1;
        @(negedge clk);
        check("cs_vote_ready", vif.vote_ready, 0);
        check("cs_s1_we", mem_we, 1);
        check("cs_s1_waddr", mem_waddr, 9001);
        check("cs_s1_wdata", mem_wdata, 1);
        tick(); clear_start = 1'b0; drive_vote(0, 0, 0);
        @(negedge clk);
        check("cs_busy", clear_busy, 1);
        check("cs_sweep0", mem_waddr, 0);
        for (int i = 0; i < 99; i++) @(negedge clk);
        check("cs_sweep99", mem_waddr, 99);
        tick(); reset = 1'b1;
        @(negedge clk);
        check("abort_we", mem_we, 0);
        tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_busy", clear_busy, 0);
            check("abort_done", clear_done, 0);
            check("abort_ready", vif.vote_ready, 1);
        end

        // Mid-vote reset discards the pending write
        tick(); drive_vote(1, 3, 8);
        tick(); drive_vote(0, 0, 0); reset = 1'b1;
        @(negedge clk);
        check("midrst_we", mem_we, 0);
        tick(); reset = 1'b0;
        tick(); drive_vote(1, 3, 8);
        tick(); drive_vote(0, 0, 0);
        @(negedge clk);
        check("midrst_wdata", mem_wdata, 2);

        // Random votes, with a hot set near bin 0 to stress forwarding
        for (int i = 0; i < 600; i++) begin
            int r, ang;
            tick();
            if ($urandom_range(0, 2) == 0) r = -800 + int'($urandom_range(0, 5));
            else                           r = int'($urandom_range(0, 1630)) - 815;
            if ($urandom_range(0, 4) == 0) ang = int'($urandom_range(0, 255));
            else if ($urandom_range(0, 1) == 0) ang = 4 * int'($urandom_range(0, 2));
            else                           ang = 4 * int'($urandom_range(0, 46));
            drive_vote($urandom_range(0, 3) != 0, r, ang);
        end
        tick(); drive_vote(0, 0, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hough_vote_accumulator.md
Name: hough_vote_accumulator

Overview:
- Consumes the (r, angle) vote stream from the Hough calculate stage.
- Bins each vote and performs a read-modify-write increment on an external dual-port accumulator BRAM (count = vote tally per bin).
- Provides a clear sweep that zeroes every bin before a new frame.
- The find-highest stage reads the same BRAM afterwards.

Parameters:
R_MAX, 800, max |r|; valid r range is -R_MAX..+R_MAX inclusive
ANGLE_BINS, 45, number of angle bins (angle step 4, angles 0..176)
COUNT_W, 16, bin counter width
ADDR_W, 15, BRAM address width; must cover NUM_BINS = (R_MAX/2+1)*ANGLE_BINS (18045 at defaults)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
vote_valid  in  1  vote present this cycle
vote_ready  out  1  vote accepted when vote_valid & vote_ready
vote_r  in  13  signed radius
vote_angle  in  8  angle in degrees, multiple of 4
clear_start  in  1  one-cycle pulse: begin zeroing all bins
clear_busy  out  1  high during the sweep
clear_done  out  1  one-cycle pulse after the last zero is written
mem_raddr  out  ADDR_W  BRAM read address (port A), combinational from vote inputs
mem_rdata  in  COUNT_W  BRAM read data, valid 1 cycle after mem_raddr
mem_we  out  1  BRAM write enable (port B)
mem_waddr  out  ADDR_W  BRAM write address
mem_wdata  out  COUNT_W  BRAM write data
votes_accepted  out  16  count of binned votes since last clear
votes_dropped  out  16  count of out-of-range votes since last clear

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: ACCUM. All outputs reset to 0 except vote_ready = 1. Pipeline and forward registers are invalidated. BRAM contents are not touched.
- States:
  - ACCUM: vote_ready = !clear_start.
    - clear_start -> CLEAR next cycle.
    - clear_start while clear_busy is ignored.
  - CLEAR: vote_ready = 0, clear_busy = 1.
    - One write per cycle: mem_we = 1, mem_waddr = sweep counter 0..NUM_BINS-1, mem_wdata = 0.
    - After address NUM_BINS-1: clear_done pulses the next cycle, return to ACCUM, stats counters zero.
- Binning, combinational in the accept cycle:
  - Valid when angle[1:0] == 0, angle <= 4*(ANGLE_BINS-1), and -R_MAX <= r <= R_MAX.
  - a_bin = angle >> 2.
  - r_bin = (r + R_MAX) >> 2 (arithmetic; -800 -> 0, 800 -> 400).
  - addr = r_bin*ANGLE_BINS + a_bin.
  - Invalid votes are accepted (handshake completes) but do not enter the pipeline; votes_dropped increments.
- Pipeline, one vote per cycle sustained:
  - Cycle t: accept; mem_raddr = addr; s1_valid/s1_addr registered.
  - Cycle t+1: base = (fw_valid && fw_addr == s1_addr) ? fw_data : mem_rdata.
  - new = base + 1, saturating at 2^COUNT_W-1.
  - mem_we = 1, mem_waddr = s1_addr, mem_wdata = new, all combinational.
  - fw_valid/addr/data capture that write at the end of t+1.
  - Latency: vote to write-enable = 1 cycle.
- Forwarding covers the back-to-back same-bin case, since the BRAM is read-first. Votes to the same bin 2+ cycles apart read the committed value.
- clear_start while s1 is valid: the s1 write completes in that cycle; the sweep starts the next cycle. fw_valid clears on entering CLEAR.
- Reset during CLEAR: abort immediately; no clear_done; BRAM left partially cleared.
- Mid-vote reset: the pending s1 write is discarded.
- votes_accepted and votes_dropped saturate at 16'hFFFF.

Optional Feature:
- HOUGH_ACC_STATS_EN defined: votes_accepted and votes_dropped count as specified.
- Undefined: both are tied to 0, their counters are not synthesized, and the binning/drop logic is unchanged.

Test Plan:
- Reset, clear_start pulse -> clear_busy is high for exactly 18045 cycles; mem_we writes 0 to addresses 0..18044 in order; clear_done pulses once; vote_ready is 0 throughout.
- After clear, vote (r=0, angle=88) -> mem_raddr = 200*45+22 = 9022; next cycle mem_we = 1, mem_waddr = 9022, mem_wdata = 1 (mem_rdata = 0).
- Three consecutive cycles of vote (r=-800, angle=176), BRAM model read-first -> writes to addr 44 with data 1, 2, 3 (forward path exercised).
- Votes (r=801, angle=0), (r=0, angle=2), (r=0, angle=180) -> no mem_we; votes_dropped = 3, votes_accepted = 0 (STATS_EN defined); all are 0 when undefined.
- mem_rdata = 16'hFFFF on a vote -> mem_wdata = 16'hFFFF (saturation).
- clear_start in the same cycle as vote_valid while s1 is valid -> vote_ready = 0 and the vote is not accepted; the pending s1 write completes; the sweep starts the next cycle. A reset at sweep address 100 -> state ACCUM, no clear_done, vote_ready = 1.
